// File: rtl/block_locator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : block_locator
//  Purpose  : Watches the pixel stream and recovers the bounding box
//             (x, y, width, height) of a solid-colour block.
//             Results update once per frame, with a one-cycle valid strobe.
//  Options  : BLOCK_LOCATOR_CENTROID_EN adds a centroid output.
//             It computes sum_x/count and sum_y/count with restoring dividers.
//             This raises the frame_done -> valid latency to 35 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module block_locator #(
    parameter logic [23:0] COLOR      = 24'hFF_FF_FF,
    parameter int          TOL        = 8,
    parameter int          MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    input  logic        frame_done_in,
    output logic        valid_out,
    output logic        found_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [10:0] width_out,
    output logic [9:0]  height_out,
    output logic [19:0] pixel_count_out,
    output logic [10:0] centroid_x_out,
    output logic [9:0]  centroid_y_out
);

    localparam logic [8:0]  c_tol        = 9'(TOL);
    localparam logic [19:0] c_min_pixels = 20'(MIN_PIXELS);
    localparam logic [19:0] c_count_max  = 20'hF_FFFF;
    localparam logic [10:0] c_min_x_init = 11'd2047;
    localparam logic [9:0]  c_min_y_init = 10'd1023;

    localparam logic [1:0]  c_st_accum   = 2'd0;
    localparam logic [1:0]  c_st_divide  = 2'd1;
    localparam logic [1:0]  c_st_report  = 2'd2;

    // Channel distance in 9 bits so values near 0 or 255 never wrap around
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        if (a >= b) begin
            return {1'b0, a} - {1'b0, b};
        end
        return {1'b0, b} - {1'b0, a};
    endfunction

    logic        w_match;
    logic        r_match_q;
    logic [10:0] r_hcount_q;
    logic [9:0]  r_vcount_q;
    logic        r_done_q;

    logic [10:0] r_min_x, r_max_x, w_min_x_nxt, w_max_x_nxt;
    logic [9:0]  r_min_y, r_max_y, w_min_y_nxt, w_max_y_nxt;
    logic [19:0] r_count, w_count_nxt;

    logic [10:0] r_snap_min_x, r_snap_max_x;
    logic [9:0]  r_snap_min_y, r_snap_max_y;
    logic [19:0] r_snap_count;

    logic [1:0]  r_state;
    logic        w_take_snap;
    logic        w_found;

    assign w_match = data_valid_in
                  && (abs_diff(red_in,   COLOR[23:16]) <= c_tol)
                  && (abs_diff(green_in, COLOR[15:8])  <= c_tol)
                  && (abs_diff(blue_in,  COLOR[7:0])   <= c_tol);

    assign w_found = (r_snap_count >= c_min_pixels);

    // Stage 1: register the match decision alongside its coordinates
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_match_q  <= 1'b0;
            r_hcount_q <= '0;
            r_vcount_q <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_match_q  <= w_match;
            r_hcount_q <= hcount_in;
            r_vcount_q <= vcount_in;
            r_done_q   <= frame_done_in;
        end
    end

    // Accumulator update including the current stage-1 pixel; this is also what a snapshot captures
    always_comb begin
        w_min_x_nxt = r_min_x;
        w_max_x_nxt = r_max_x;
        w_min_y_nxt = r_min_y;
        w_max_y_nxt = r_max_y;
        w_count_nxt = r_count;
        if (r_match_q) begin
            if (r_hcount_q < r_min_x) w_min_x_nxt = r_hcount_q;
            if (r_hcount_q > r_max_x) w_max_x_nxt = r_hcount_q;
            if (r_vcount_q < r_min_y) w_min_y_nxt = r_vcount_q;
            if (r_vcount_q > r_max_y) w_max_y_nxt = r_vcount_q;
            if (r_count != c_count_max) w_count_nxt = r_count + 20'd1;
        end
    end

    // Stage 2: accumulate, restarting the frame at every frame close
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_min_x <= c_min_x_init;
            r_max_x <= '0;
            r_min_y <= c_min_y_init;
            r_max_y <= '0;
            r_count <= '0;
        end else if (r_done_q) begin
            r_min_x <= c_min_x_init;
            r_max_x <= '0;
            r_min_y <= c_min_y_init;
            r_max_y <= '0;
            r_count <= '0;
        end else begin
            r_min_x <= w_min_x_nxt;
            r_max_x <= w_max_x_nxt;
            r_min_y <= w_min_y_nxt;
            r_max_y <= w_max_y_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Hold the closing frame's statistics until they are reported
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_snap_min_x <= '0;
            r_snap_max_x <= '0;
            r_snap_min_y <= '0;
            r_snap_max_y <= '0;
            r_snap_count <= '0;
        end else if (w_take_snap) begin
            r_snap_min_x <= w_min_x_nxt;
            r_snap_max_x <= w_max_x_nxt;
            r_snap_min_y <= w_min_y_nxt;
            r_snap_max_y <= w_max_y_nxt;
            r_snap_count <= w_count_nxt;
        end
    end

`ifdef BLOCK_LOCATOR_CENTROID_EN
    logic [31:0] r_sum_x, r_sum_y, w_sum_x_nxt, w_sum_y_nxt;
    logic [31:0] r_div;
    logic [31:0] r_quo_x, r_quo_y, r_rem_x, r_rem_y;
    logic [5:0]  r_iter;
    logic [32:0] w_rem_sh_x, w_rem_sh_y, w_sub_x, w_sub_y;
    logic        w_div_busy;

    // A frame close that lands while dividing is dropped (no new snapshot)
    assign w_take_snap = r_done_q && (r_state != c_st_divide);
    assign w_div_busy  = (r_state == c_st_divide) && (r_iter != 6'd32);

    assign w_sum_x_nxt = r_sum_x + (r_match_q ? 32'(r_hcount_q) : 32'd0);
    assign w_sum_y_nxt = r_sum_y + (r_match_q ? 32'(r_vcount_q) : 32'd0);

    assign w_rem_sh_x  = {r_rem_x, r_quo_x[31]};
    assign w_rem_sh_y  = {r_rem_y, r_quo_y[31]};
    assign w_sub_x     = w_rem_sh_x - {1'b0, r_div};
    assign w_sub_y     = w_rem_sh_y - {1'b0, r_div};

    // Coordinate sums over matched pixels, cleared at each frame close
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
        end else if (r_done_q) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
        end else begin
            r_sum_x <= w_sum_x_nxt;
            r_sum_y <= w_sum_y_nxt;
        end
    end

    // Two restoring dividers sharing one divisor and iteration counter
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div   <= '0;
            r_quo_x <= '0;
            r_quo_y <= '0;
            r_rem_x <= '0;
            r_rem_y <= '0;
            r_iter  <= 6'd32;
        end else if (w_take_snap) begin
            r_div   <= {12'd0, w_count_nxt};
            r_quo_x <= w_sum_x_nxt;
            r_quo_y <= w_sum_y_nxt;
            r_rem_x <= '0;
            r_rem_y <= '0;
            r_iter  <= 6'd0;
        end else if (w_div_busy) begin
            r_iter <= r_iter + 6'd1;
            if (!w_sub_x[32]) begin
                r_rem_x <= w_sub_x[31:0];
                r_quo_x <= {r_quo_x[30:0], 1'b1};
            end else begin
                r_rem_x <= w_rem_sh_x[31:0];
                r_quo_x <= {r_quo_x[30:0], 1'b0};
            end
            if (!w_sub_y[32]) begin
                r_rem_y <= w_sub_y[31:0];
                r_quo_y <= {r_quo_y[30:0], 1'b1};
            end else begin
                r_rem_y <= w_rem_sh_y[31:0];
                r_quo_y <= {r_quo_y[30:0], 1'b0};
            end
        end
    end

    // Centroid outputs update only with a found frame
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            centroid_x_out <= '0;
            centroid_y_out <= '0;
        end else if ((r_state == c_st_report) && w_found) begin
            centroid_x_out <= r_quo_x[10:0];
            centroid_y_out <= r_quo_y[9:0];
        end
    end
`else
    assign w_take_snap    = r_done_q;
    assign centroid_x_out = '0;
    assign centroid_y_out = '0;
`endif

    // Control FSM: sequence snapshot -> (divide) -> report, registering the results
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= c_st_accum;
            valid_out       <= 1'b0;
            found_out       <= 1'b0;
            x_out           <= '0;
            y_out           <= '0;
            width_out       <= '0;
            height_out      <= '0;
            pixel_count_out <= '0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                c_st_accum: begin
                    if (r_done_q) begin
`ifdef BLOCK_LOCATOR_CENTROID_EN
                        r_state <= c_st_divide;
`else
                        r_state <= c_st_report;
`endif
                    end
                end
                c_st_divide: begin
`ifdef BLOCK_LOCATOR_CENTROID_EN
                    if (r_iter == 6'd32) r_state <= c_st_report;
`else
                    r_state <= c_st_accum;
`endif
                end
                c_st_report: begin
                    valid_out       <= 1'b1;
                    found_out       <= w_found;
                    pixel_count_out <= r_snap_count;
                    if (w_found) begin
                        x_out      <= r_snap_min_x;
                        y_out      <= r_snap_min_y;
                        width_out  <= r_snap_max_x - r_snap_min_x + 11'd1;
                        height_out <= r_snap_max_y - r_snap_min_y + 10'd1;
                    end
                    // A frame close in this cycle was snapshotted; report it next
                    if (r_done_q) begin
`ifdef BLOCK_LOCATOR_CENTROID_EN
                        r_state <= c_st_divide;
`else
                        r_state <= c_st_report;
`endif
                    end else begin
                        r_state <= c_st_accum;
                    end
                end
                default: r_state <= c_st_accum;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_locator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_block_locator
//  Purpose  : Self-checking bench for block_locator.
//             It applies a table of rectangle frames, then hand-written
//             multi-cycle sequences (coincident frame_done, back-to-back
//             frames, reset mid-frame, colour aliasing near 0/255).
//  Revision : 1.0  initial release
// ============================================================================
module tb_block_locator;

`ifdef BLOCK_LOCATOR_CENTROID_EN
    localparam int LAT = 35;
    localparam bit CEN = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit CEN = 1'b0;
`endif
    localparam logic [23:0] WHITE = 24'hFF_FF_FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        dv = 1'b0;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic        fd = 1'b0;

    logic        valid, found;
    logic [10:0] x, width, cx;
    logic [9:0]  y, height, cy;
    logic [19:0] count;

    logic        valid2, found2;
    logic [10:0] x2, width2, cx2;
    logic [9:0]  y2, height2, cy2;
    logic [19:0] count2;

    int n_tests = 0;
    int n_fail  = 0;

    block_locator dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .data_valid_in(dv), .red_in(red), .green_in(green), .blue_in(blue),
        .frame_done_in(fd), .valid_out(valid), .found_out(found), .x_out(x),
        .y_out(y), .width_out(width), .height_out(height),
        .pixel_count_out(count), .centroid_x_out(cx), .centroid_y_out(cy)
    );

    block_locator #(.COLOR(24'h08_08_08), .TOL(8), .MIN_PIXELS(16)) dut2 (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .data_valid_in(dv), .red_in(red), .green_in(green), .blue_in(blue),
        .frame_done_in(fd), .valid_out(valid2), .found_out(found2), .x_out(x2),
        .y_out(y2), .width_out(width2), .height_out(height2),
        .pixel_count_out(count2), .centroid_x_out(cx2), .centroid_y_out(cy2)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (act=running req=finished)");
        $fatal(1);
    end

    typedef struct {
        int          x0, y0, w, h;
        logic [23:0] rgb;
        bit          e_found;
        int          ex, ey, ew, eh, ecnt, ecx, ecy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int px, input int py, input logic [23:0] rgb,
                          input logic v, input logic done);
        hcount = 11'(px);
        vcount = 10'(py);
        {red, green, blue} = rgb;
        dv = v;
        fd = done;
    endtask

    task automatic drive(input int px, input int py, input logic [23:0] rgb,
                         input logic v, input logic done);
        set_in(px, py, rgb, v, done);
        tick();
    endtask

    // Called right after the cycle in which frame_done_in was sampled
    task automatic wait_valid(input string tag);
        int lat;
        set_in(0, 0, 24'h0, 1'b0, 1'b0);
        lat = 0;
        while (!valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!valid) chk({tag, ".timeout"}, 0, 1);
        else        chk({tag, ".latency"}, lat, LAT);
    endtask

    task automatic chk_res(input string tag, input bit ef, input int ex, input int ey,
                           input int ew, input int eh, input int ecnt,
                           input int ecx, input int ecy);
        chk({tag, ".found"},  int'(found),  int'(ef));
        chk({tag, ".x"},      int'(x),      ex);
        chk({tag, ".y"},      int'(y),      ey);
        chk({tag, ".width"},  int'(width),  ew);
        chk({tag, ".height"}, int'(height), eh);
        chk({tag, ".count"},  int'(count),  ecnt);
        chk({tag, ".cx"},     int'(cx),     CEN ? ecx : 0);
        chk({tag, ".cy"},     int'(cy),     CEN ? ecy : 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},  int'(valid),  0);
        chk({tag, ".found"},  int'(found),  0);
        chk({tag, ".x"},      int'(x),      0);
        chk({tag, ".y"},      int'(y),      0);
        chk({tag, ".width"},  int'(width),  0);
        chk({tag, ".height"}, int'(height), 0);
        chk({tag, ".count"},  int'(count),  0);
        chk({tag, ".cx"},     int'(cx),     0);
    endtask

    initial begin
        int   nv;
        bit   vf[4];
        int   vc[4];
        int   vx[4];

        //         x0   y0   w    h    rgb          f  ex   ey  ew   eh   cnt    cx   cy
        vecs[0] = '{100, 50, 128, 128, WHITE,       1, 100, 50, 128, 128, 16384, 163, 113};
        vecs[1] = '{10,  10, 4,   4,   24'hF7F7F7,  1, 10,  10, 4,   4,   16,    11,  11};
        vecs[2] = '{40,  20, 10,  10,  WHITE,       1, 40,  20, 10,  10,  100,   44,  24};
        vecs[3] = '{40,  20, 10,  10,  24'hF6FFFF,  0, 40,  20, 10,  10,  0,     44,  24};
        vecs[4] = '{500, 300, 5,  3,   WHITE,       0, 40,  20, 10,  10,  15,    44,  24};

        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(2, 2, 24'h000000, 1'b1, 1'b0);
            for (int r = 0; r < vecs[i].h; r++)
                for (int c = 0; c < vecs[i].w; c++)
                    drive(vecs[i].x0 + c, vecs[i].y0 + r, vecs[i].rgb, 1'b1, 1'b0);
            drive(1000, 600, WHITE, 1'b0, 1'b0);
            drive(0, 0, 24'h0, 1'b0, 1'b1);
            wait_valid(tag);
            chk_res(tag, vecs[i].e_found, vecs[i].ex, vecs[i].ey, vecs[i].ew,
                    vecs[i].eh, vecs[i].ecnt, vecs[i].ecx, vecs[i].ecy);
            repeat (2) tick();
        end

        // Extreme corners
        drive(0, 0, WHITE, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) drive(1279, 719, WHITE, 1'b1, 1'b0);
        drive(0, 0, 24'h0, 1'b0, 1'b1);
        wait_valid("corners");
        chk_res("corners", 1, 0, 0, 1280, 720, 16, 1199, 674);
        repeat (2) tick();

        // Colour aliasing around 0/255 (second instance targets 08_08_08)
        drive(3, 3, 24'h000000, 1'b1, 1'b0);
        drive(4, 3, 24'h110808, 1'b1, 1'b0);
        drive(5, 3, 24'hFF0808, 1'b1, 1'b0);
        drive(0, 0, 24'h0, 1'b0, 1'b1);
        wait_valid("alias");
        chk("alias.valid2", int'(valid2), 1);
        chk("alias.found2", int'(found2), 0);
        chk("alias.count2", int'(count2), 1);
        repeat (2) tick();

        // Pixel coincident with frame_done belongs to the closing frame
        for (int k = 0; k < 15; k++) drive(300, 200, WHITE, 1'b1, 1'b0);
        drive(300, 200, WHITE, 1'b1, 1'b1);
        wait_valid("coinc");
        chk_res("coinc", 1, 300, 200, 1, 1, 16, 300, 200);
        repeat (2) tick();
        drive(0, 0, 24'h0, 1'b0, 1'b1);
        wait_valid("empty");
        chk_res("empty", 0, 300, 200, 1, 1, 0, 300, 200);
        repeat (2) tick();

        // Back-to-back frame_done pulses one cycle apart
        for (int k = 0; k < 16; k++) drive(5 + k, 5, WHITE, 1'b1, 1'b0);
        drive(0, 0, 24'h0, 1'b0, 1'b1);
        drive(7, 9, WHITE, 1'b1, 1'b1);
        set_in(0, 0, 24'h0, 1'b0, 1'b0);
        nv = 0;
        for (int k = 0; k < 60; k++) begin
            if (valid && nv < 4) begin
                vf[nv] = found;
                vc[nv] = int'(count);
                vx[nv] = int'(x);
                nv++;
            end
            tick();
        end
        chk("b2b.nvalid", nv, CEN ? 1 : 2);
        if (nv >= 1) begin
            chk("b2b.found0", int'(vf[0]), 1);
            chk("b2b.count0", vc[0], 16);
            chk("b2b.x0", vx[0], 5);
        end
        if (!CEN && nv >= 2) begin
            chk("b2b.found1", int'(vf[1]), 0);
            chk("b2b.count1", vc[1], 1);
            chk("b2b.x1", vx[1], 5);
        end

        // Reset mid-frame discards the partial frame
        for (int k = 0; k < 20; k++) drive(60 + k, 61, WHITE, 1'b1, 1'b0);
        set_in(0, 0, 24'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_zero("rst_after");
        drive(0, 0, 24'h0, 1'b0, 1'b1);
        wait_valid("post_rst");
        chk_res("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_locator.md
Name: block_locator

Overview:
- Frame-level inverse of the block sprite renderer: observes the pixel stream plus hcount/vcount and recovers the position and size of a solid-colour block.
- Outputs an (x, y, width, height) bounding box in the same coordinate convention the sprite renderer consumes.
- Sits after the camera/pixel pipeline and feeds tracking logic, which can drive a sprite's x_in/y_in.
- Results update once per frame, with a one-cycle valid strobe.

Parameters:
- COLOR, 24'hFF_FF_FF, target colour {R[23:16], G[15:8], B[7:0]}.
- TOL, 8, max allowed absolute difference per channel for a pixel to match (inclusive).
- MIN_PIXELS, 16, minimum matched pixels in a frame for found_out=1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- hcount_in  input  11  pixel column of current sample
- vcount_in  input  10  pixel row of current sample
- data_valid_in  input  1  sample is an active-area pixel
- red_in / green_in / blue_in  input  8 each  pixel colour
- frame_done_in  input  1  one-cycle pulse after the last pixel of a frame (may coincide with that pixel)
- valid_out  output  1  one-cycle strobe: new result latched
- found_out  output  1  block detected in last reported frame
- x_out  output  11  bounding-box left column
- y_out  output  10  bounding-box top row
- width_out  output  11  max_x-min_x+1
- height_out  output  10  max_y-min_y+1
- pixel_count_out  output  20  matched pixels in last frame (saturating)
- centroid_x_out  output  11  see Optional Feature
- centroid_y_out  output  10  see Optional Feature

Behaviour:
- Reset (async assert, sync-safe release): all outputs 0; accumulators min_x=2047, min_y=1023, max_x=0, max_y=0, count=0; FSM in ACCUM.
- Match: data_valid_in && |R-COLOR_R|<=TOL && |G-COLOR_G|<=TOL && |B-COLOR_B|<=TOL. Differences use 9-bit unsigned arithmetic, no wrap. Channel values near 0/255 must not alias.
- Stage 1 (edge after sample): register match_q, hcount_q, vcount_q, done_q.
- Stage 2 (accumulate): if match_q, update min/max and count. count saturates at 2^20-1.
- Frame close: the cycle done_q=1 is the snapshot. The snapshot includes the match_q of that same cycle, so a pixel coincident with frame_done_in belongs to the closing frame. Accumulators return to reset values at the same edge.
- Result rules:
  - count>=MIN_PIXELS: found_out=1; x/y/width/height/pixel_count from snapshot.
  - Otherwise: found_out=0; pixel_count_out=count; x/y/width/height hold their previous values.
- Latency: valid_out high exactly 2 cycles after frame_done_in is sampled (feature off). Outputs stable until the next valid_out.
- FSM states ACCUM, DIVIDE, REPORT. DIVIDE is used only with the feature; feature off: ACCUM->REPORT(1 cycle)->ACCUM.
- Accumulation continues in every state; pixels of the next frame are never lost.
- Back-to-back frame_done pulses 1 cycle apart: each produces its own result. The second frame covers only the intervening pixels.
- Reset mid-frame: partial frame discarded, no valid_out.

Optional Feature:
- Macro: BLOCK_LOCATOR_CENTROID_EN.
- Defined:
  - Extra accumulators sum_x (32b) and sum_y (32b) over matched pixels.
  - At snapshot the FSM enters DIVIDE: two parallel 32-iteration restoring dividers compute sum_x/count and sum_y/count.
  - REPORT then latches centroid_x_out/centroid_y_out together with all other results.
  - valid_out occurs exactly 35 cycles after frame_done_in.
  - A done_q arriving during DIVIDE is dropped: accumulators are cleared and no valid_out is produced for that frame.
  - Centroid outputs hold when found_out=0.
- Undefined: centroid outputs tied to 0, no sum or divider logic, 2-cycle latency.

Test Plan:
- Pixels matching COLOR on the rectangle x=100..227, y=50..177, all other pixels black, then frame_done_in -> 2 cycles later valid_out=1, found_out=1, x_out=100, y_out=50, width_out=128, height_out=128, pixel_count_out=16384.
- Single matching pixel at (0,0) plus 15 at (1279,719) -> x_out=0, y_out=0, width_out=1280, height_out=720, pixel_count_out=16.
- Only 15 matching pixels after a found frame -> found_out=0, pixel_count_out=15, x/y/width/height unchanged.
- COLOR=24'h08_08_08, TOL=8; pixels 00_00_00 (match), 11_08_08 (no match), FF_08_08 (no match; no wrap) -> pixel_count_out=1.
- Matching pixel at (300,200) coincident with frame_done_in, then next frame empty -> first result includes (300,200); second result found_out=0, pixel_count_out=0.
- rst_in asserted mid-frame then frame_done_in with no pixels -> all outputs 0 during reset; post-reset result found_out=0, pixel_count_out=0. With BLOCK_LOCATOR_CENTROID_EN, a 10x10 block at x=40, y=20 gives centroid_x_out=44, centroid_y_out=24 and valid_out 35 cycles after frame_done_in.
